// File: rtl/fetch_unit.sv
// Instruction fetch stage for the tiny5 core: issues word-aligned fetches
// and queues in-order responses for decode, flushing on redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        mem_req_valid_o,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_req_ready_i,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [CW+1:0] DEPTH_W = (CW + 2)'(QUEUE_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(QUEUE_DEPTH - 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   q_instr [QUEUE_DEPTH];
    logic [31:0]   q_pc    [QUEUE_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW+1:0] credit;
    logic [CW-1:0] inflight_next;
    logic [31:0]   target;
    logic          req_acc;
    logic          push;
    logic          pop;

    // Every in-flight request, kept or doomed, holds a queue slot.
    assign credit = {2'b00, outstanding} + {2'b00, discard}
                  + {2'b00, count};

    assign mem_req_valid_o = !reset_i && (credit < DEPTH_W);
    assign mem_req_addr_o  = fetch_pc;
    assign instr_valid_o   = !reset_i && (count != '0);
    assign instr_o         = q_instr[head];
    assign instr_pc_o      = q_pc[head];

    assign req_acc = mem_req_valid_o && mem_req_ready_i;
    assign pop     = instr_valid_o && instr_ready_i;
    assign push    = mem_rsp_valid_i && !redirect_valid_i
                   && (discard == '0);
    assign target  = {redirect_pc_i[31:2], 2'b00};

    assign inflight_next = outstanding + discard + CW'(req_acc)
                         - CW'(mem_rsp_valid_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (redirect_valid_i) begin
            // Everything still in flight becomes stale.
            fetch_pc    <= target;
            rsp_pc      <= target;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= inflight_next;
        end else begin
            if (req_acc) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (mem_rsp_valid_i && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            outstanding <= outstanding + CW'(req_acc) - CW'(push);
            if (push) begin
                q_instr[tail] <= mem_rsp_data_i;
                q_pc[tail]    <= rsp_pc;
                tail          <= (tail == LAST) ? '0 : tail + PW'(1);
                rsp_pc        <= rsp_pc + 32'd4;
            end
            if (pop) begin
                head <= (head == LAST) ? '0 : head + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a request/response-level model
// of the fetch stream, with directed scenarios pinning key timings.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h100;
    localparam int          D   = 2;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        mem_req_valid_o;
    logic [31:0] mem_req_addr_o;
    logic        mem_req_ready_i;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(D)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_ready_i   (instr_ready_i)
    );

    // In-flight fetches (also the memory's pending list) and decode queue.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          stale;
        int          due;
    } fl_t;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } qe_t;

    fl_t         fl[$];
    qe_t         dq[$];
    logic [31:0] m_pc = RPC;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          lat = 1;
    int          rsp_pct = 100;

    logic        o_req;
    logic [31:0] o_addr;
    logic        o_ivalid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h want %h",
                      name, cyc, act, exp);
    endtask

    task automatic step(bit rst, bit mrdy, bit redir,
                        logic [31:0] rpc, bit irdy);
        bit          e_req;
        bit          e_rsp;
        bit          e_iv;
        bit          acc;
        logic [31:0] a;
        fl_t         f;
        @(negedge clk);
        reset_i          = rst;
        mem_req_ready_i  = mrdy;
        redirect_valid_i = redir;
        redirect_pc_i    = rpc;
        instr_ready_i    = irdy;
        e_rsp = 1'b0;
        if (!rst && fl.size() > 0) begin
            if (cyc >= fl[0].due && $urandom_range(99) < rsp_pct)
                e_rsp = 1'b1;
        end
        mem_rsp_valid_i = e_rsp;
        if (e_rsp) mem_rsp_data_i = fl[0].data;
        else mem_rsp_data_i = $urandom;
        #1;
        e_req = !rst && (fl.size() + dq.size() < D);
        e_iv  = !rst && (dq.size() != 0);
        chk("req_valid", {31'b0, mem_req_valid_o}, {31'b0, e_req});
        if (e_req) begin
            chk("req_addr", mem_req_addr_o, m_pc);
            chk("req_align", {30'b0, mem_req_addr_o[1:0]}, 32'h0);
        end
        chk("instr_valid", {31'b0, instr_valid_o}, {31'b0, e_iv});
        if (e_iv) begin
            chk("instr", instr_o, dq[0].instr);
            chk("instr_pc", instr_pc_o, dq[0].pc);
            chk("pc_align", {30'b0, instr_pc_o[1:0]}, 32'h0);
        end
        o_req    = mem_req_valid_o;
        o_addr   = mem_req_addr_o;
        o_ivalid = instr_valid_o;
        o_instr  = instr_o;
        o_pc     = instr_pc_o;
        if (rst) begin
            fl.delete();
            dq.delete();
            m_pc = RPC;
        end else begin
            acc = e_req && mrdy;
            a   = m_pc;
            if (e_rsp) f = fl.pop_front();
            if (e_iv && irdy) void'(dq.pop_front());
            if (redir) begin
                foreach (fl[i]) fl[i].stale = 1'b1;
                dq.delete();
            end else if (e_rsp && !f.stale) begin
                dq.push_back('{instr: f.data, pc: f.addr});
            end
            if (acc)
                fl.push_back('{addr: a, data: $urandom, stale: redir,
                               due: cyc + lat});
            if (redir) m_pc = {rpc[31:2], 2'b00};
            else if (acc) m_pc = a + 32'd4;
        end
        cyc++;
    endtask

    task automatic do_reset();
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
    endtask

    task automatic find_first(logic [31:0] want_addr,
                              logic [31:0] want_pc, string tag);
        bit got_req = 0;
        bit got_iv  = 0;
        for (int i = 0; i < 40 && !(got_req && got_iv); i++) begin
            step(0, 1, 0, 0, 1);
            if (o_req && !got_req) begin
                got_req = 1;
                chk({tag, "_first_req"}, o_addr, want_addr);
            end
            if (o_ivalid && !got_iv) begin
                got_iv = 1;
                chk({tag, "_first_pc"}, o_pc, want_pc);
            end
        end
        chk({tag, "_timeout"}, {30'b0, got_req, got_iv}, 32'h3);
    endtask

    initial begin
        int          pops;
        bit          rr;
        logic [31:0] tgt;
        reset_i          = 1'b1;
        mem_req_ready_i  = 1'b1;
        mem_rsp_valid_i  = 1'b0;
        mem_rsp_data_i   = '0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        instr_ready_i    = 1'b1;

        // Streaming from reset with single-cycle memory
        do_reset();
        step(0, 1, 0, 0, 1);
        chk("t1_req", {31'b0, o_req}, 32'h1);
        chk("t1_addr", o_addr, 32'h100);
        chk("t1_ivalid0", {31'b0, o_ivalid}, 32'h0);
        chk("t1_instr0", o_instr, 32'h0);
        chk("t1_pc0", o_pc, 32'h0);
        step(0, 1, 0, 0, 1);
        chk("t1_ivalid1", {31'b0, o_ivalid}, 32'h0);
        step(0, 1, 0, 0, 1);
        chk("t1_ivalid2", {31'b0, o_ivalid}, 32'h1);
        chk("t1_pc", o_pc, 32'h100);
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 0, 1);
            if (o_ivalid) pops++;
        end
        chk("t1_rate", {31'b0, pops >= 10}, 32'h1);

        // Decode stall fills the queue, then drains in order
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
        chk("t2_req_off", {31'b0, o_req}, 32'h0);
        chk("t2_full", {31'b0, o_ivalid}, 32'h1);
        chk("t2_head", o_pc, 32'h100);
        lat = 4;
        step(0, 1, 0, 0, 1);
        chk("t2_pop0", o_pc, 32'h100);
        step(0, 1, 0, 0, 1);
        chk("t2_pop1", o_pc, 32'h104);
        chk("t2_resume", {31'b0, o_req}, 32'h1);
        chk("t2_resume_addr", o_addr, 32'h108);

        // Redirect with 0x108 and 0x10C in flight
        step(0, 1, 0, 0, 1);
        chk("t3_addr", o_addr, 32'h10C);
        step(0, 1, 1, 32'h2002, 1);
        chk("t3_no_req", {31'b0, o_req}, 32'h0);
        find_first(32'h2000, 32'h2000, "t3");

        // Redirect, acceptance and response in one cycle
        lat = 1;
        do_reset();
        step(0, 1, 0, 0, 1);
        step(0, 1, 1, 32'h3000, 1);
        chk("t4_acc", {31'b0, o_req}, 32'h1);
        find_first(32'h3000, 32'h3000, "t4");

        // Memory not ready holds the address
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1);
            chk("t5_hold", o_addr, 32'h100);
        end
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("t5_next", o_addr, 32'h104);

        // Reset with a full queue
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
        chk("t6_full", {31'b0, o_ivalid}, 32'h1);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        chk("t6_ivalid", {31'b0, o_ivalid}, 32'h0);
        chk("t6_addr", o_addr, RPC);

        // Randomised traffic
        rsp_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) lat = $urandom_range(1, 3);
            rr = ($urandom_range(99) < 5);
            if ($urandom_range(3) == 0)
                tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            else
                tgt = $urandom;
            step($urandom_range(199) == 0, $urandom_range(99) < 70,
                 rr, tgt, $urandom_range(99) < 60);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
